// File: rtl/rx_frame_deframer.sv
// rx_frame_deframer: hunts for the sync header in the received byte stream, then captures the seed and reassembles the payload words.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   rx_enable             - receive mode; low aborts to HUNT and suppresses all pulses
//   rx_data, rx_done      - received byte and its one-cycle strobe
//   sync_en               - pulse when the 32-bit seed is complete
//   sync_state_out        - captured seed, held until the next capture
//   payload_word          - assembled 16-bit word, held until the next word
//   payload_valid         - pulse per assembled word
//   next_key_en           - same timing as payload_valid
//   frame_done            - pulse with the last word of a frame
//   frame_err             - pulse on inter-byte timeout
//   locked                - high from sync_en until frame_err, rx_enable low or reset
module rx_frame_deframer #(
    parameter int          PAYLOAD_WORDS  = 16,
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [15:0] SYNC_WORD      = 16'hCAFE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_enable,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        sync_en,
    output logic [31:0] sync_state_out,
    output logic [15:0] payload_word,
    output logic        payload_valid,
    output logic        next_key_en,
    output logic        frame_done,
    output logic        frame_err,
    output logic        locked
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int WW = $clog2(PAYLOAD_WORDS + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [WW-1:0] WLAST   = WW'(PAYLOAD_WORDS - 1);

    typedef enum logic [1:0] {HUNT, GOT_HI, SEED, PAYLOAD} state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [23:0]   seed_q, seed_d;
    logic [7:0]    hi_q, hi_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   sync_state_q, sync_state_d;
    logic [15:0]   payload_word_q, payload_word_d;
    logic          sync_en_q, sync_en_d;
    logic          payload_valid_q, payload_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;
    logic          locked_q, locked_d;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        seed_d          = seed_q;
        hi_d            = hi_q;
        wcnt_d          = wcnt_q;
        tmo_d           = tmo_q;
        sync_state_d    = sync_state_q;
        payload_word_d  = payload_word_q;
        sync_en_d       = 1'b0;
        payload_valid_d = 1'b0;
        frame_done_d    = 1'b0;
        frame_err_d     = 1'b0;
        locked_d        = locked_q;
        if (!rx_enable) begin
            state_d  = HUNT;
            tmo_d    = '0;
            locked_d = 1'b0;
        end else if (rx_done) begin
            // an accepted byte always restarts the timeout, even in its expiry cycle
            tmo_d = '0;
            case (state_q)
                HUNT: state_d = (rx_data == SYNC_WORD[15:8]) ? GOT_HI : HUNT;
                GOT_HI: begin
                    idx_d   = '0;
                    state_d = (rx_data == SYNC_WORD[7:0])  ? SEED :
                              (rx_data == SYNC_WORD[15:8]) ? GOT_HI : HUNT;
                end
                SEED: begin
                    seed_d = {seed_q[15:0], rx_data};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        sync_state_d = {seed_q, rx_data};
                        sync_en_d    = 1'b1;
                        locked_d     = 1'b1;
                        wcnt_d       = '0;
                        idx_d        = '0;
                        state_d      = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    // idx_q[0] tracks the byte parity within the current word
                    idx_d = {1'b0, ~idx_q[0]};
                    hi_d  = idx_q[0] ? hi_q : rx_data;
                    if (idx_q[0]) begin
                        payload_word_d  = {hi_q, rx_data};
                        payload_valid_d = 1'b1;
                        wcnt_d          = wcnt_q + WW'(1);
                        if (wcnt_q == WLAST) begin
                            frame_done_d = 1'b1;
                            state_d      = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end else if (state_q != HUNT) begin
            if (tmo_q == TMO_MAX) begin
                frame_err_d = 1'b1;
                locked_d    = 1'b0;
                tmo_d       = '0;
                state_d     = HUNT;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= HUNT;
            idx_q           <= '0;
            seed_q          <= '0;
            hi_q            <= '0;
            wcnt_q          <= '0;
            tmo_q           <= '0;
            sync_state_q    <= '0;
            payload_word_q  <= '0;
            sync_en_q       <= 1'b0;
            payload_valid_q <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_err_q     <= 1'b0;
            locked_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            seed_q          <= seed_d;
            hi_q            <= hi_d;
            wcnt_q          <= wcnt_d;
            tmo_q           <= tmo_d;
            sync_state_q    <= sync_state_d;
            payload_word_q  <= payload_word_d;
            sync_en_q       <= sync_en_d;
            payload_valid_q <= payload_valid_d;
            frame_done_q    <= frame_done_d;
            frame_err_q     <= frame_err_d;
            locked_q        <= locked_d;
        end
    end

    assign sync_en        = sync_en_q;
    assign sync_state_out = sync_state_q;
    assign payload_word   = payload_word_q;
    assign payload_valid  = payload_valid_q;
    assign next_key_en    = payload_valid_q;
    assign frame_done     = frame_done_q;
    assign frame_err      = frame_err_q;
    assign locked         = locked_q;
endmodule

// File: tb/tb_rx_frame_deframer.sv
// tb_rx_frame_deframer: table-driven check of rx_frame_deframer with PAYLOAD_WORDS=2, TIMEOUT_CYCLES=20.
module tb_rx_frame_deframer;
    logic        clk = 1'b0;
    logic        rst_n, rx_enable, rx_done;
    logic [7:0]  rx_data;
    logic        sync_en, payload_valid, next_key_en, frame_done, frame_err, locked;
    logic [31:0] sync_state_out;
    logic [15:0] payload_word;

    rx_frame_deframer #(.PAYLOAD_WORDS(2), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst_n(rst_n), .rx_enable(rx_enable), .rx_data(rx_data), .rx_done(rx_done),
        .sync_en(sync_en), .sync_state_out(sync_state_out), .payload_word(payload_word),
        .payload_valid(payload_valid), .next_key_en(next_key_en), .frame_done(frame_done),
        .frame_err(frame_err), .locked(locked)
    );

    always #5 clk = ~clk;

    // pulse vector: {sync_en, payload_valid, next_key_en, frame_done, frame_err}
    localparam logic [4:0] SE = 5'b10000, PV = 5'b01100, FD = 5'b00010, FE = 5'b00001;

    typedef struct {
        logic        en;
        logic        dn;
        logic [7:0]  d;
        logic [4:0]  p;
        logic        lk;
        logic [31:0] s;
        logic [15:0] w;
    } vec_t;

    vec_t        q[$];
    logic [31:0] es = '0;
    logic [15:0] ew = '0;
    int          total = 0;
    int          bad = 0;
    int          base = 0;

    function automatic void v(input logic en, input logic dn, input logic [7:0] d, input logic [4:0] p, input logic lk);
        q.push_back('{en, dn, d, p, lk, es, ew});
    endfunction

    function automatic void byt(input logic [7:0] d, input logic [4:0] p, input logic lk);
        v(1'b1, 1'b1, d, p, lk);
    endfunction

    function automatic void idl(input int n, input logic lk);
        for (int i = 0; i < n; i++) v(1'b1, 1'b0, 8'h00, 5'b0, lk);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic run();
        logic [4:0] pul;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            rx_enable = q[i].en;
            rx_done   = q[i].dn;
            rx_data   = q[i].d;
            @(posedge clk);
            #1;
            pul = {sync_en, payload_valid, next_key_en, frame_done, frame_err};
            chk($sformatf("v%0d pulses", base + i), 32'(pul), 32'(q[i].p));
            chk($sformatf("v%0d locked", base + i), 32'(locked), 32'(q[i].lk));
            chk($sformatf("v%0d seed", base + i), sync_state_out, q[i].s);
            chk($sformatf("v%0d word", base + i), 32'(payload_word), 32'(q[i].w));
        end
        base += q.size();
        q.delete();
        rx_done = 1'b0;
        rx_enable = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rx_enable = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", 32'({sync_en, payload_valid, next_key_en, frame_done, frame_err, locked}), 32'd0);
        chk("reset seed", sync_state_out, 32'd0);
        chk("reset word", 32'(payload_word), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // clean frame, back-to-back strobes
        byt(8'hCA, 0, 0); byt(8'hFE, 0, 0); byt(8'h12, 0, 0); byt(8'h34, 0, 0); byt(8'h56, 0, 0);
        es = 32'h12345678; byt(8'h78, SE, 1);
        byt(8'hAB, 0, 1); ew = 16'hABCD; byt(8'hCD, PV, 1);
        byt(8'h01, 0, 1); ew = 16'h0102; byt(8'h02, PV | FD, 1);
        // hunt robustness, payload containing the header bytes
        v(1'b0, 1'b0, 8'h00, 0, 0);
        byt(8'h00, 0, 0); byt(8'hCA, 0, 0); byt(8'hCA, 0, 0); byt(8'hFE, 0, 0);
        byt(8'h00, 0, 0); byt(8'h00, 0, 0); byt(8'h00, 0, 0);
        es = 32'h00000001; byt(8'h01, SE, 1);
        byt(8'hCA, 0, 1); ew = 16'hCAFE; byt(8'hFE, PV, 1);
        byt(8'h00, 0, 1); ew = 16'h0000; byt(8'h00, PV | FD, 1);
        // false header, then bytes that would complete a seed if not back in HUNT
        v(1'b0, 1'b0, 8'h00, 0, 0);
        byt(8'hCA, 0, 0); byt(8'h11, 0, 0); byt(8'hFE, 0, 0);
        for (int i = 0; i < 4; i++) byt(8'h00, 0, 0);
        // timeout during the seed on exactly the 20th idle cycle
        byt(8'hCA, 0, 0); byt(8'hFE, 0, 0); byt(8'h12, 0, 0); byt(8'h34, 0, 0);
        idl(19, 0);
        v(1'b1, 1'b0, 8'h00, FE, 0);
        idl(1, 0);
        byt(8'hCA, 0, 0); byt(8'hFE, 0, 0); byt(8'h87, 0, 0); byt(8'h65, 0, 0); byt(8'h43, 0, 0);
        es = 32'h87654321; byt(8'h21, SE, 1);
        byt(8'h11, 0, 1); ew = 16'h1122; byt(8'h22, PV, 1);
        byt(8'h33, 0, 1); ew = 16'h3344; byt(8'h44, PV | FD, 1);
        // abort after 3 payload bytes; abort beats a simultaneous strobe
        byt(8'hCA, 0, 1); byt(8'hFE, 0, 1); byt(8'h01, 0, 1); byt(8'h02, 0, 1); byt(8'h03, 0, 1);
        es = 32'h01020304; byt(8'h04, SE, 1);
        byt(8'hA1, 0, 1); ew = 16'hA1B2; byt(8'hB2, PV, 1);
        byt(8'hC3, 0, 1);
        v(1'b0, 1'b1, 8'hD4, 0, 0);
        for (int i = 0; i < 25; i++) v(1'b0, 1'b0, 8'h00, 0, 0);
        idl(25, 0);
        byt(8'hCA, 0, 0); byt(8'hFE, 0, 0); byt(8'h0A, 0, 0); byt(8'h0B, 0, 0); byt(8'h0C, 0, 0);
        es = 32'h0A0B0C0D; byt(8'h0D, SE, 1);
        byt(8'hE1, 0, 1); ew = 16'hE1E2; byt(8'hE2, PV, 1);
        byt(8'hF1, 0, 1); ew = 16'hF1F2; byt(8'hF2, PV | FD, 1);
        // byte arriving in the expiry cycle wins, then a payload timeout
        v(1'b0, 1'b0, 8'h00, 0, 0);
        byt(8'hCA, 0, 0); byt(8'hFE, 0, 0);
        idl(19, 0);
        byt(8'h55, 0, 0); byt(8'h66, 0, 0); byt(8'h77, 0, 0);
        es = 32'h55667788; byt(8'h88, SE, 1);
        idl(19, 1);
        v(1'b1, 1'b0, 8'h00, FE, 0);
        byt(8'h99, 0, 0);
        // locked frame, then stop mid-seed for the reset
        byt(8'hCA, 0, 0); byt(8'hFE, 0, 0); byt(8'h12, 0, 0); byt(8'h34, 0, 0); byt(8'h56, 0, 0);
        es = 32'h12345678; byt(8'h78, SE, 1);
        byt(8'hAB, 0, 1); ew = 16'hABCD; byt(8'hCD, PV, 1);
        byt(8'h01, 0, 1); ew = 16'h0102; byt(8'h02, PV | FD, 1);
        byt(8'hCA, 0, 1); byt(8'hFE, 0, 1); byt(8'h12, 0, 1);
        run();

        // asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst outputs", 32'({sync_en, payload_valid, next_key_en, frame_done, frame_err, locked}), 32'd0);
        chk("async rst seed", sync_state_out, 32'd0);
        chk("async rst word", 32'(payload_word), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        es = '0;
        ew = '0;
        byt(8'hCA, 0, 0); byt(8'hFE, 0, 0); byt(8'hDE, 0, 0); byt(8'hAD, 0, 0); byt(8'hBE, 0, 0);
        es = 32'hDEADBEEF; byt(8'hEF, SE, 1);
        byt(8'h55, 0, 1); ew = 16'h55AA; byt(8'hAA, PV, 1);
        byt(8'h0F, 0, 1); ew = 16'h0FF0; byt(8'hF0, PV | FD, 1);
        run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
